// File: rtl/regfile_pkg.sv
// Shared constants and packing helpers for the
// scoreboarded integer register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NUM_WR     = 2;

  // Load write-back (port 1) beats ALU (port 0)
  localparam int unsigned WR_HI = 1;
  localparam int unsigned WR_LO = 0;

  function automatic int unsigned slice_lo(
    input int unsigned k,
    input int unsigned w
  );
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reservation ack, write clear, flush.
// Ports: wr_ok/wr_addr (accepted writes), rsv_*, flush, busy, ack.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_ok,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic                     ack
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [NREG-1:0]   clr;
  logic [NREG-1:0]   set;
  logic [ADDR_W-1:0] wa;
  logic              rsv_zero;

  always_comb begin
    clr = '0;
    wa  = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      wa = wr_addr[slice_lo(p, ADDR_W) +: ADDR_W];
      if (wr_ok[p]) clr[wa] = 1'b1;
    end
  end

  assign rsv_zero = (ZERO_REG != 0) &&
                    (rsv_addr == '0);

  // A write landing on the target frees it this cycle
  assign ack = rst_n && rsv_en && !flush &&
               (!busy[rsv_addr] || clr[rsv_addr] ||
                rsv_zero);

  always_comb begin
    set = '0;
    if (ack && !rsv_zero) set[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     busy <= '0;
    else if (flush) busy <= '0;
    else            busy <= (busy & ~clr) | set;
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with forwarding and busy scoreboard.
// Ports: rd_addr/data/busy, wr_en/addr/data, rsv_en/addr/ack, flush.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic                     rsv_en_i,
  input  logic [ADDR_W-1:0]        rsv_addr_i,
  output logic                     rsv_ack_o,
  input  logic                     flush_i
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [NREG];
  logic [ADDR_W-1:0] wa  [NUM_WR];
  logic [DATA_W-1:0] wd  [NUM_WR];
  logic [NUM_WR-1:0] wr_ok;
  logic [NREG-1:0]   busy;

  for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
    assign wa[p] = wr_addr_i[slice_lo(p, ADDR_W) +: ADDR_W];
    assign wd[p] = wr_data_i[slice_lo(p, DATA_W) +: DATA_W];
    assign wr_ok[p] = wr_en_i[p] &&
                      (wa[p] != '0 || ZERO_REG == 0);
  end

  // High-priority port assigned last so it wins on a tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else begin
      if (wr_ok[WR_LO]) mem[wa[WR_LO]] <= wd[WR_LO];
      if (wr_ok[WR_HI]) mem[wa[WR_HI]] <= wd[WR_HI];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    logic              hit_hi;
    logic              hit_lo;
    logic              is_zero;

    assign ra = rd_addr_i[slice_lo(k, ADDR_W) +: ADDR_W];
    assign hit_hi  = wr_ok[WR_HI] && (wa[WR_HI] == ra);
    assign hit_lo  = wr_ok[WR_LO] && (wa[WR_LO] == ra);
    assign is_zero = (ZERO_REG != 0) && (ra == '0);

    always_comb begin
      d = mem[ra];
      if (hit_lo)            d = wd[WR_LO];
      if (hit_hi)            d = wd[WR_HI];
      if (!rst_n || is_zero) d = '0;
    end

    assign rd_data_o[slice_lo(k, DATA_W) +: DATA_W] = d;
    assign rd_busy_o[k] = rst_n && busy[ra] &&
                          !(hit_hi || hit_lo);
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_ok    (wr_ok),
    .wr_addr  (wr_addr_i),
    .rsv_en   (rsv_en_i),
    .rsv_addr (rsv_addr_i),
    .flush    (flush_i),
    .busy     (busy),
    .ack      (rsv_ack_o)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default, ZERO_REG=0
// and a 64-bit / 6-bit / 3-read-port instance.
module tb_regfile_sb;

  logic clk;
  logic rst_n;

  // instance a: defaults, ZERO_REG=1
  logic [9:0]  rd_addr_a;
  logic [63:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic [1:0]  wr_en_a;
  logic [9:0]  wr_addr_a;
  logic [63:0] wr_data_a;
  logic        rsv_en_a;
  logic [4:0]  rsv_addr_a;
  logic        ack_a;
  logic        flush_a;

  // instance b: ZERO_REG=0
  logic [9:0]  rd_addr_b;
  logic [63:0] rd_data_b;
  logic [1:0]  rd_busy_b;
  logic [1:0]  wr_en_b;
  logic [9:0]  wr_addr_b;
  logic [63:0] wr_data_b;
  logic        rsv_en_b;
  logic [4:0]  rsv_addr_b;
  logic        ack_b;
  logic        flush_b;

  // instance c: 64-bit, 6-bit addr, 3 read ports
  logic [17:0]  rd_addr_c;
  logic [191:0] rd_data_c;
  logic [2:0]   rd_busy_c;
  logic [1:0]   wr_en_c;
  logic [11:0]  wr_addr_c;
  logic [127:0] wr_data_c;
  logic         rsv_en_c;
  logic [5:0]   rsv_addr_c;
  logic         ack_c;
  logic         flush_c;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_sb u_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr_i  (rd_addr_a),
    .rd_data_o  (rd_data_a),
    .rd_busy_o  (rd_busy_a),
    .wr_en_i    (wr_en_a),
    .wr_addr_i  (wr_addr_a),
    .wr_data_i  (wr_data_a),
    .rsv_en_i   (rsv_en_a),
    .rsv_addr_i (rsv_addr_a),
    .rsv_ack_o  (ack_a),
    .flush_i    (flush_a)
  );

  regfile_sb #(.ZERO_REG(0)) u_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr_i  (rd_addr_b),
    .rd_data_o  (rd_data_b),
    .rd_busy_o  (rd_busy_b),
    .wr_en_i    (wr_en_b),
    .wr_addr_i  (wr_addr_b),
    .wr_data_i  (wr_data_b),
    .rsv_en_i   (rsv_en_b),
    .rsv_addr_i (rsv_addr_b),
    .rsv_ack_o  (ack_b),
    .flush_i    (flush_b)
  );

  regfile_sb #(
    .DATA_W (64),
    .ADDR_W (6),
    .NUM_RD (3)
  ) u_c (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr_i  (rd_addr_c),
    .rd_data_o  (rd_data_c),
    .rd_busy_o  (rd_busy_c),
    .wr_en_i    (wr_en_c),
    .wr_addr_i  (wr_addr_c),
    .wr_data_i  (wr_data_c),
    .rsv_en_i   (rsv_en_c),
    .rsv_addr_i (rsv_addr_c),
    .rsv_ack_o  (ack_c),
    .flush_i    (flush_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got 1 want 0");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    rd_addr_a  = '0; wr_en_a = '0;
    wr_addr_a  = '0; wr_data_a = '0;
    rsv_en_a   = 1'b1; rsv_addr_a = 5'd6;
    flush_a    = 1'b0;
    rd_addr_b  = '0; wr_en_b = '0;
    wr_addr_b  = '0; wr_data_b = '0;
    rsv_en_b   = 1'b0; rsv_addr_b = '0;
    flush_b    = 1'b0;
    rd_addr_c  = '0; wr_en_c = '0;
    wr_addr_c  = '0; wr_data_c = '0;
    rsv_en_c   = 1'b0; rsv_addr_c = '0;
    flush_c    = 1'b0;

    // held reset: outputs quiet even with a request
    #2;
    chk("rst_data", rd_data_a, 64'h0);
    chk("rst_busy", {62'h0, rd_busy_a}, 64'h0);
    chk("rst_ack", {63'h0, ack_a}, 64'h0);
    tick();
    rst_n = 1'b1;
    rsv_en_a = 1'b0;
    tick();

    // reserve x5, then reset in the middle of its write
    rsv_en_a = 1'b1; rsv_addr_a = 5'd5;
    #1;
    chk("x5_ack", {63'h0, ack_a}, 64'h1);
    tick();
    rsv_en_a = 1'b0;
    rd_addr_a[4:0] = 5'd5;
    #1;
    chk("x5_busy", {62'h0, rd_busy_a}, 64'h1);
    wr_en_a = 2'b01;
    wr_addr_a[4:0] = 5'd5;
    wr_data_a[31:0] = 32'hDEADBEEF;
    #1;
    chk("x5_fwd", rd_data_a, 64'hDEADBEEF);
    #1;
    rst_n = 1'b0;
    #1;
    chk("x5_rst_data", rd_data_a, 64'h0);
    chk("x5_rst_busy", {62'h0, rd_busy_a}, 64'h0);
    tick();
    wr_en_a = 2'b00;
    tick();
    rst_n = 1'b1;
    #1;
    chk("x5_post_data", rd_data_a, 64'h0);
    chk("x5_post_busy", {62'h0, rd_busy_a}, 64'h0);
    tick();

    // dual write to x7, load port wins
    wr_en_a = 2'b11;
    wr_addr_a = {5'd7, 5'd7};
    wr_data_a = {32'h22, 32'h11};
    rd_addr_a = {5'd7, 5'd0};
    #1;
    chk("x7_fwd", rd_data_a[63:32], 64'h22);
    tick();
    wr_en_a = 2'b00;
    #1;
    chk("x7_stored", rd_data_a[63:32], 64'h22);
    tick();

    // zero register behaviour on both flavours
    wr_en_a = 2'b01;
    wr_addr_a = '0;
    wr_data_a = 64'hFF;
    rsv_en_a = 1'b1; rsv_addr_a = 5'd0;
    rd_addr_a = '0;
    wr_en_b = 2'b01;
    wr_addr_b = '0;
    wr_data_b = 64'hFF;
    rd_addr_b = '0;
    #1;
    chk("x0_fwd", rd_data_a[31:0], 64'h0);
    chk("x0_ack", {63'h0, ack_a}, 64'h1);
    chk("x0_busy", {62'h0, rd_busy_a}, 64'h0);
    chk("x0b_fwd", rd_data_b[31:0], 64'hFF);
    tick();
    wr_en_a = 2'b00; rsv_en_a = 1'b0;
    wr_en_b = 2'b00;
    #1;
    chk("x0_stored", rd_data_a[31:0], 64'h0);
    chk("x0_busy2", {62'h0, rd_busy_a}, 64'h0);
    chk("x0b_stored", rd_data_b[31:0], 64'hFF);

    // scoreboard sequence on x3
    rd_addr_a = {5'd0, 5'd3};
    rsv_en_a = 1'b1; rsv_addr_a = 5'd3;
    #1;
    chk("x3_ack1", {63'h0, ack_a}, 64'h1);
    tick();
    #1;
    chk("x3_busy1", {63'h0, rd_busy_a[0]}, 64'h1);
    chk("x3_ack2", {63'h0, ack_a}, 64'h0);
    tick();
    rsv_en_a = 1'b0;
    #1;
    chk("x3_hold", {63'h0, rd_busy_a[0]}, 64'h1);
    wr_en_a = 2'b01;
    wr_addr_a = {5'd0, 5'd3};
    wr_data_a = 64'h40;
    #1;
    chk("x3_fwd", rd_data_a[31:0], 64'h40);
    chk("x3_fbusy", {63'h0, rd_busy_a[0]}, 64'h0);
    tick();
    wr_en_a = 2'b00;
    #1;
    chk("x3_clr", {63'h0, rd_busy_a[0]}, 64'h0);
    rsv_en_a = 1'b1;
    tick();
    wr_en_a = 2'b01;
    wr_data_a = 64'h41;
    #1;
    chk("x3_rw_ack", {63'h0, ack_a}, 64'h1);
    tick();
    wr_en_a = 2'b00; rsv_en_a = 1'b0;
    #1;
    chk("x3_rw_busy", {63'h0, rd_busy_a[0]}, 64'h1);
    chk("x3_rw_data", rd_data_a[31:0], 64'h41);

    // reserve x1, x2, x9 then flush against x4
    rsv_en_a = 1'b1;
    rsv_addr_a = 5'd1;
    #1;
    chk("x1_ack", {63'h0, ack_a}, 64'h1);
    tick();
    rsv_addr_a = 5'd2;
    tick();
    rsv_addr_a = 5'd9;
    tick();
    rsv_addr_a = 5'd4;
    flush_a = 1'b1;
    wr_en_a = 2'b10;
    wr_addr_a = {5'd9, 5'd0};
    wr_data_a = {32'h99, 32'h0};
    #1;
    chk("fl_ack", {63'h0, ack_a}, 64'h0);
    tick();
    flush_a = 1'b0; rsv_en_a = 1'b0;
    wr_en_a = 2'b00;
    rd_addr_a = {5'd2, 5'd1};
    #1;
    chk("fl_b12", {62'h0, rd_busy_a}, 64'h0);
    rd_addr_a = {5'd4, 5'd9};
    #1;
    chk("fl_b94", {62'h0, rd_busy_a}, 64'h0);
    chk("fl_x9", rd_data_a[31:0], 64'h99);
    rd_addr_a = {5'd0, 5'd3};
    #1;
    chk("fl_b3", {62'h0, rd_busy_a}, 64'h0);

    // wide instance, all three ports on x63
    wr_en_c = 2'b01;
    wr_addr_c = {6'd0, 6'd63};
    wr_data_c = {64'h0, 64'h0123456789ABCDEF};
    rd_addr_c = {6'd63, 6'd63, 6'd63};
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("c_fwd%0d", k),
          rd_data_c[k*64 +: 64],
          64'h0123456789ABCDEF);
    tick();
    wr_en_c = 2'b00;
    rd_addr_c = {6'd63, 6'd62, 6'd63};
    #1;
    chk("c_rd0", rd_data_c[63:0],
        64'h0123456789ABCDEF);
    chk("c_rd1", rd_data_c[127:64], 64'h0);
    chk("c_rd2", rd_data_c[191:128],
        64'h0123456789ABCDEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
